// File: rtl/seq_subtractor.sv
// -----------------------------------------------------------------------------
// seq_subtractor
//
// Multi-cycle subtractor. It computes diff = a - b - b_in (modulo 2^WIDTH),
// working on SLICE bits per clock, least-significant slice first, and carrying
// the borrow from one slice into the next. A full operation takes
// N = WIDTH/SLICE RUN cycles. WIDTH must be an integer multiple of SLICE.
//
// Optional feature macro: SEQ_SUBTRACTOR_OVF_EN
//   defined   : ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), taken from
//               the latched operands and registered together with the flags.
//   undefined : ovf is tied to 0 and no overflow logic exists.
//
// Ports
//   clk    in   clock; all state changes happen on its rising edge
//   rst_n  in   synchronous active-low reset; takes priority over start
//   start  in   request one subtraction (accepted in IDLE or DONE)
//   a      in   WIDTH-bit minuend
//   b      in   WIDTH-bit subtrahend
//   b_in   in   borrow in
//   busy   out  operation in progress
//   done   out  one-cycle pulse: diff/b_out/zero/ovf were just updated
//   diff   out  WIDTH-bit result, held until the next completion or reset
//   b_out  out  final borrow; 1 iff unsigned a < b + b_in
//   zero   out  1 iff diff == 0
//   ovf    out  signed overflow flag (see macro above)
// -----------------------------------------------------------------------------
module seq_subtractor #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero,
  output logic             ovf
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   partial;
  logic               borrow;
  logic [CNT_W-1:0]   cnt;

  logic [SLICE:0]     slice_ext;
  logic [WIDTH-1:0]   next_partial;
  logic               borrow_next;
  logic               last_slice;

  // One slice of the subtraction. The extra top bit of slice_ext goes to 1
  // exactly when the slice result is negative, i.e. when it produces a borrow.
  // NOTE: every signal written here is given a default first, so no path
  // leaves it unassigned and no latch can be inferred.
  always_comb begin
    next_partial = partial;
    slice_ext    = {1'b0, a_q[cnt*SLICE +: SLICE]}
                 - {1'b0, b_q[cnt*SLICE +: SLICE]}
                 - {{SLICE{1'b0}}, borrow};
    next_partial[cnt*SLICE +: SLICE] = slice_ext[SLICE-1:0];
    borrow_next  = slice_ext[SLICE];
    last_slice   = (cnt == CNT_W'(N - 1));
  end

  // Single-process FSM with registered outputs. The reset is sampled on the
  // clock edge, so it is simply the first branch and wins over start.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      b_out   <= 1'b0;
      zero    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      partial <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
`ifdef SEQ_SUBTRACTOR_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // done is a pulse: it is only ever high for the cycle spent in DONE.
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            borrow  <= b_in;      // the first slice borrows b_in
            partial <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end

        RUN: begin
          // start is ignored here; the latched operands stay untouched.
          partial <= next_partial;
          borrow  <= borrow_next;
          cnt     <= cnt + 1'b1;
          if (last_slice) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= next_partial;
            b_out <= borrow_next;
            zero  <= (next_partial == '0);
`ifdef SEQ_SUBTRACTOR_OVF_EN
            ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                     (next_partial[WIDTH-1] != a_q[WIDTH-1]);
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SEQ_SUBTRACTOR_OVF_EN
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// -----------------------------------------------------------------------------
// tb_seq_subtractor
//
// Self-checking bench for seq_subtractor (WIDTH=64, SLICE=16, so N=4).
// Stimulus pushes the expected result of each accepted operation into a
// queue; an independent monitor pops and compares whenever done is high.
// Expected values come from plain wide arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_seq_subtractor;

  localparam int W = 64;
  localparam int S = 16;
  localparam int N = W / S;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         b_out;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;
  logic         zero;
  logic         ovf;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  seq_subtractor #(.WIDTH(W), .SLICE(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out),
    .zero  (zero),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: the result is the wrapped difference; the borrow is decided by
  // an unsigned comparison of a against b + b_in in one extra bit.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic bi);
    exp_t       e;
    logic [W:0] lhs;
    logic [W:0] rhs;
    lhs     = {1'b0, x};
    rhs     = {1'b0, y} + (W+1)'(bi);
    e.diff  = x - y - W'(bi);
    e.b_out = (lhs < rhs);
    e.zero  = (e.diff == '0);
`ifdef SEQ_SUBTRACTOR_OVF_EN
    e.ovf   = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
`else
    e.ovf   = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("diff",  diff,  e.diff);
        check("b_out", W'(b_out), W'(e.b_out));
        check("zero",  W'(zero),  W'(e.zero));
        check("ovf",   W'(ovf),   W'(e.ovf));
      end
    end
  end

  // Wait (bounded) for done; expects exactly N edges after the start edge.
  // Called at the negedge right after the start edge.
  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, W'(lat), W'(N));
    check({name, "_busy_at_done"}, W'(busy), 0);
  endtask

  // One complete operation. Operands are scrambled right after the start edge
  // to confirm they were latched.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic bi, input bit sync);
    if (sync) @(negedge clk);
    a     = x;
    b     = y;
    b_in  = bi;
    start = 1'b1;
    exp_q.push_back(model(x, y, bi));
    @(negedge clk);
    start = 1'b0;
    a     = {$urandom, $urandom};
    b     = {$urandom, $urandom};
    b_in  = 1'($urandom_range(0, 1));
    check("busy_after_start", W'(busy), 1);
    wait_done("op");
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = W'($urandom_range(0, 65536));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] x;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_busy",  W'(busy),  0);
    check("rst_done",  W'(done),  0);
    check("rst_diff",  diff,      0);
    check("rst_b_out", W'(b_out), 0);
    check("rst_zero",  W'(zero),  0);
    check("rst_ovf",   W'(ovf),   0);
    rst_n = 1'b1;

    // Directed cases: small, borrow out, cross-slice borrow, signed overflow.
    op(64'd7, 64'd3, 1'b0, 1'b1);
    op(64'd0, 64'd1, 1'b0, 1'b1);
    op(64'h0000_0000_0001_0000, 64'd1, 1'b0, 1'b1);
    op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    op('1, '1, 1'b1, 1'b1);
    op(64'd0, 64'd0, 1'b1, 1'b1);
    op(64'h0001_0000_0000_0000, 64'd0, 1'b1, 1'b1);

    // Back-to-back: start held high through the whole operation.
    @(negedge clk);
    a     = 64'd5;
    b     = 64'd5;
    b_in  = 1'b0;
    start = 1'b1;
    exp_q.push_back(model(64'd5, 64'd5, 1'b0));
    @(negedge clk);
    check("b2b_busy_first", W'(busy), 1);
    wait_done("b2b_first");
    exp_q.push_back(model(64'd5, 64'd5, 1'b0));
    @(negedge clk);
    check("b2b_restart_busy", W'(busy), 1);
    check("b2b_done_dropped", W'(done), 0);
    start = 1'b0;
    wait_done("b2b_second");

    // Reset after the second slice edge aborts the operation.
    @(negedge clk);
    a     = {$urandom, $urandom};
    b     = {$urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;   // reset must win over start
    @(negedge clk);
    check("abort_busy", W'(busy), 0);
    check("abort_done", W'(done), 0);
    check("abort_diff", diff,     0);
    check("abort_zero", W'(zero), 0);
    rst_n = 1'b1;
    op(64'd9, 64'd2, 1'b0, 1'b0);

    // Randomized operations, including operands with equal values.
    for (int i = 0; i < 40; i++) begin
      x = pick();
      if ($urandom_range(0, 5) == 0) op(x, x, 1'b0, 1'b1);
      else                           op(x, pick(), 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
